dpram_sc_init: RTL and testbench
================================

// Module: dpram_sc_init
// PURPOSE
//  Parametrised single-clock dual-port RAM: one write port, one read port, generalised width/depth.
//  Adds per-byte write masks, a read-valid strobe and a hardware init sweep that fills every word after reset or clear.
//  Serves as the general buffer for sample/filter stores in the audio/MEMS pipeline.
//  Supersedes the fixed 16x256 two-clock RAM where both sides share one clock.
// PARAMETERS
//  DATA_W    16             word width; must be a multiple of BYTE_W
//  ADDR_W    8              address width
//  DEPTH     (1<<ADDR_W)    words implemented; must be <= 2**ADDR_W
//  BYTE_W    8              lane width for wmask
//  INIT_VAL  0              value written to every word by the init sweep
// PORTS
//  clk     in   1                clock, all logic on posedge
//  rst_n   in   1                asynchronous active-low reset
//  clear   in   1                synchronous request to re-run the init sweep
//  ready   out  1                1 = sweep done, ports accept requests
//  we      in   1                write enable
//  waddr   in   ADDR_W           write address
//  wdata   in   DATA_W           write data
//  wmask   in   DATA_W/BYTE_W    per-lane write enable, bit i -> wdata[i*BYTE_W +: BYTE_W]
//  re      in   1                read enable
//  raddr   in   ADDR_W           read address
//  rdata   out  DATA_W           read data, held until the next accepted read
//  rvalid  out  1                1-cycle strobe, rdata updated this cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): rdata=0, rvalid=0, ready=0, FSM=INIT, init counter=0. RAM contents are not touched by reset itself.
//  - FSM INIT: writes INIT_VAL to address cnt each cycle; cnt increments 0..DEPTH-1.
//  - On the edge writing DEPTH-1, FSM goes to RUN. ready=1 from the next cycle: DEPTH cycles after rst_n deasserts.
//  - While ready=0, we and re are ignored: no write, no rvalid.
//  - clear=1 in RUN: FSM->INIT, cnt=0, ready=0 next cycle. Any read accepted in the same cycle still completes.
//  - clear=1 during INIT restarts cnt at 0.
//  - Write: we=1 & ready=1 -> lanes with wmask=1 updated at the edge; other lanes keep old data. wmask=0 is a no-op.
//  - Read: re=1 & ready=1 at edge N -> rdata=mem[raddr] and rvalid=1 after edge N. Latency 1; back-to-back reads sustain 1/cycle.
//  - Read: rvalid drops after edge N+1 unless re is repeated.
//  - Out of range (addr >= DEPTH): writes are dropped; reads return rdata=0 with rvalid=1.
//  - Read/write same address, same cycle: see CONFIGURATION.
//  - Read/write different addresses, same cycle: fully independent.
//  - Reset mid-sweep or mid-operation: the sweep restarts from 0. Partial contents are overwritten before ready rises.
// CONFIGURATION
//  DPRAM_BYPASS_EN defined:
//   - Same-address collision returns the merged new word: wdata on wmask=1 lanes, old memory data on the others.
//   - Read-after-write hazard free; the forward mux sits on the rdata path.
//  DPRAM_BYPASS_EN undefined:
//   - Same-address collision returns the old word (read-before-write).
//   - The write still takes effect; the next read sees the new data.
// TESTING
//  1. Release rst_n, no stimulus -> ready=0 for exactly DEPTH cycles, then 1. Read all addresses -> every rdata=INIT_VAL, one rvalid per re.
//  2. Write 0xBEEF @0x10 wmask=2'b11, then 0x1234 @0x10 wmask=2'b01, then read @0x10 -> rdata=0xBE34, rvalid 1 cycle after re.
//  3. Mem @0x20 = 0x0000. Same cycle: we=1 re=1 addr 0x20 wdata 0xA5A5 wmask=2'b10.
//     BYPASS_EN: rdata=0xA500. Without: rdata=0x0000. Next read either way -> 0xA500.
//  4. Assert clear for 1 cycle in RUN with mem @5=0x5555 -> ready=0 next cycle for DEPTH cycles, we/re ignored; afterwards read @5 = INIT_VAL.
//  5. Drop rst_n mid-sweep at cnt=37 -> ready=0, rvalid=0, rdata=0 immediately.
//     After release: a full DEPTH-cycle sweep, then ready=1.
//  6. DEPTH=200, ADDR_W=8: write @250, then read @250 -> rdata=0, rvalid=1. Read @199 -> INIT_VAL, i.e. no aliasing.

Source files
------------

// File: rtl/dpram_sc_init.sv
// Single-clock dual-port RAM with per-byte write masks, read-valid strobe and a post-reset/clear init sweep.
// Optional feature: define DPRAM_BYPASS_EN to forward same-address writes onto the read path.
module dpram_sc_init #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = (1 << ADDR_W),
    parameter int                BYTE_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    output logic                       ready,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [DATA_W/BYTE_W-1:0]   wmask,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid
);

    localparam int              LANES   = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              waddr_in;
    logic              raddr_in;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_word;

    // Lanes with mask=1 take the new data, the rest keep the old word.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [LANES-1:0]  mask
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (mask[i]) res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
        return res;
    endfunction

    assign ready    = (state == ST_RUN);
    assign waddr_in = ({1'b0, waddr} < DEPTH_L);
    assign raddr_in = ({1'b0, raddr} < DEPTH_L);
    assign wr_ok    = we & ready & waddr_in;
    assign rd_ok    = re & ready;

`ifdef DPRAM_BYPASS_EN
    assign rd_word = (wr_ok && (waddr == raddr)) ? merge_lanes(mem[raddr], wdata, wmask)
                                                 : mem[raddr];
`else
    assign rd_word = mem[raddr];
`endif

    // Control: sweep counter and INIT/RUN state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (clear) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            if ({1'b0, cnt} == LAST_L) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Storage: the sweep owns the array while INIT, the write port afterwards
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[cnt] <= INIT_VAL;
        end else if (wr_ok) begin
            mem[waddr] <= merge_lanes(mem[waddr], wdata, wmask);
        end
    end

    // Read port: one-cycle latency, out-of-range reads return zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_ok;
            if (rd_ok) rdata <= raddr_in ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_dpram_sc_init.sv
// Directed bench for dpram_sc_init (DEPTH=200, ADDR_W=8, INIT_VAL=16'h1E0F).
module tb_dpram_sc_init;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 200;
    localparam int          BYTE_W = 8;
    localparam logic [15:0] IV     = 16'h1E0F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              ready;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [1:0]        wmask = '0;
    logic              re = 1'b0;
    logic [ADDR_W-1:0] raddr = '0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    int n_tests = 0;
    int n_fail  = 0;

    dpram_sc_init #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .BYTE_W  (BYTE_W),
        .INIT_VAL(IV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .ready (ready),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .wmask (wmask),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata),
        .rvalid(rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
        we = 1'b1; waddr = a; wdata = d; wmask = m;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d, output logic v);
        re = 1'b1; raddr = a;
        tick();
        d = rdata; v = rvalid;
        re = 1'b0;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (!ready && k < 1000) begin
            tick();
            k++;
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        v;
        int          k;

        // Reset state
        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);

        // 1: sweep length and init contents
        rst_n = 1'b1;
        chk("rel_ready", 32'(ready), 32'd0);
        wait_ready(k);
        chk("init_len", 32'(k), 32'd200);
        for (int a = 0; a < DEPTH; a++) begin
            re = 1'b1; raddr = 8'(a);
            tick();
            chk("init_rdata", 32'(rdata), 32'(IV));
            chk("init_rvalid", 32'(rvalid), 32'd1);
        end
        re = 1'b0;
        tick();
        chk("init_rvalid_drop", 32'(rvalid), 32'd0);

        // 2: masked writes
        wr(8'h10, 16'hBEEF, 2'b11);
        wr(8'h10, 16'h1234, 2'b01);
        rd(8'h10, d, v);
        chk("mask_rdata", 32'(d), 32'h0000BE34);
        chk("mask_rvalid", 32'(v), 32'd1);
        tick();
        chk("mask_rvalid_drop", 32'(rvalid), 32'd0);
        chk("mask_rdata_hold", 32'(rdata), 32'h0000BE34);
        wr(8'h10, 16'hFFFF, 2'b00);
        rd(8'h10, d, v);
        chk("mask0_noop", 32'(d), 32'h0000BE34);

        // 3: same-address collision
        wr(8'h20, 16'h0000, 2'b11);
        we = 1'b1; waddr = 8'h20; wdata = 16'hA5A5; wmask = 2'b10;
        re = 1'b1; raddr = 8'h20;
        tick();
        we = 1'b0; re = 1'b0;
`ifdef DPRAM_BYPASS_EN
        chk("coll_rdata", 32'(rdata), 32'h0000A500);
`else
        chk("coll_rdata", 32'(rdata), 32'h00000000);
`endif
        chk("coll_rvalid", 32'(rvalid), 32'd1);
        rd(8'h20, d, v);
        chk("coll_after", 32'(d), 32'h0000A500);

        // Different addresses in the same cycle
        wr(8'h30, 16'h7777, 2'b11);
        we = 1'b1; waddr = 8'h31; wdata = 16'h1111; wmask = 2'b11;
        re = 1'b1; raddr = 8'h30;
        tick();
        we = 1'b0; re = 1'b0;
        chk("indep_rdata", 32'(rdata), 32'h00007777);
        rd(8'h31, d, v);
        chk("indep_wr", 32'(d), 32'h00001111);

        // Boundary: last in-range word
        wr(8'd199, 16'h4242, 2'b11);
        rd(8'd199, d, v);
        chk("last_word", 32'(d), 32'h00004242);

        // 4: clear in RUN, requests ignored during sweep
        wr(8'h05, 16'h5555, 2'b11);
        clear = 1'b1; re = 1'b1; raddr = 8'h10;
        tick();
        clear = 1'b0;
        chk("clr_rd_done", 32'(rdata), 32'h0000BE34);
        chk("clr_rd_valid", 32'(rvalid), 32'd1);
        chk("clr_ready", 32'(ready), 32'd0);
        we = 1'b1; waddr = 8'h00; wdata = 16'hDEAD; wmask = 2'b11;
        re = 1'b1; raddr = 8'h00;
        k = 0;
        while (!ready && k < 1000) begin
            tick();
            k++;
            if (rvalid) chk("clr_no_rvalid", 32'(rvalid), 32'd0);
        end
        we = 1'b0; re = 1'b0;
        chk("clr_len", 32'(k), 32'd200);
        chk("clr_rvalid_end", 32'(rvalid), 32'd0);
        rd(8'h05, d, v);
        chk("clr_addr5", 32'(d), 32'(IV));
        rd(8'h00, d, v);
        chk("clr_addr0", 32'(d), 32'(IV));
        rd(8'h10, d, v);
        chk("clr_addr10", 32'(d), 32'(IV));

        // Clear during INIT restarts the sweep
        wr(8'h06, 16'h6666, 2'b11);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (49) tick();
        chk("clr2_ready", 32'(ready), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_ready(k);
        chk("clr2_len", 32'(k), 32'd200);
        rd(8'h06, d, v);
        chk("clr2_addr6", 32'(d), 32'(IV));

        // 5: async reset in RUN right after a read, then mid-sweep
        wr(8'h07, 16'h9876, 2'b11);
        rd(8'h07, d, v);
        chk("pre_rst_valid", 32'(v), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_rvalid", 32'(rvalid), 32'd0);
        chk("arst_rdata", 32'(rdata), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (37) tick();
        chk("mid_ready", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ready_rst", 32'(ready), 32'd0);
        chk("mid_rvalid_rst", 32'(rvalid), 32'd0);
        chk("mid_rdata_rst", 32'(rdata), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(k);
        chk("mid_len", 32'(k), 32'd200);
        rd(8'h07, d, v);
        chk("mid_addr7", 32'(d), 32'(IV));

        // 6: out-of-range accesses, no aliasing
        wr(8'd250, 16'hCAFE, 2'b11);
        rd(8'd250, d, v);
        chk("oor_rdata", 32'(d), 32'd0);
        chk("oor_rvalid", 32'(v), 32'd1);
        rd(8'd199, d, v);
        chk("oor_alias199", 32'(d), 32'(IV));
        rd(8'd50, d, v);
        chk("oor_alias50", 32'(d), 32'(IV));
        rd(8'd122, d, v);
        chk("oor_alias122", 32'(d), 32'(IV));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
